clk_div_ratio_monitor: RTL and testbench
========================================

Name: clk_div_ratio_monitor

Overview:
- Receive-side checker for divided clocks produced by the team's divide-by-N blocks.
- Samples a slow divided clock `clk_div_in` in the fast `clk` domain and measures its period in `clk` cycles.
- Compares each period against an expected ratio and declares lock after consecutive matches.
- Flags mismatches and loss of the input clock; used in clock-tree bring-up and in always-on clock health monitoring.

Parameters:
- CNT_W, 16: width of the period counter and of the period/exp_n/high_time buses.
- LOCK_CNT, 4: consecutive matching periods required to assert locked (range 1..15).
- TOL, 0: allowed absolute deviation, in clk cycles, between measured and expected period.
- TIMEOUT, 1024: clk cycles without a rising edge before loss is declared. Must be < 2^CNT_W.

Ports:
- clk  in  1  fast reference clock.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable.
- clk_div_in  in  1  divided clock under test; asynchronous to clk.
- exp_n  in  CNT_W  expected period in clk cycles; quasi-static.
- period  out  CNT_W  last measured period.
- period_vld  out  1  one-cycle pulse when period updates.
- locked  out  1  lock status.
- mismatch  out  1  one-cycle pulse; measured period outside exp_n±TOL.
- timeout  out  1  one-cycle pulse; input clock lost.
- high_time  out  CNT_W  last measured high phase (DUTY_CHECK_EN only, else 0).
- duty_err  out  1  one-cycle pulse; duty check failed (DUTY_CHECK_EN only, else 0).

Behaviour:
- Reset values: all outputs 0; internal sync flops, cnt, match_cnt and high-phase register 0; state IDLE.
- Input conditioning:
  - clk_div_in passes through a 2-flop synchronizer (s1→s2), then a delay flop s_d.
  - rise = s2 & ~s_d; fall = ~s2 & s_d.
- States: IDLE, ARM, MEAS, LOCK.
  - IDLE: entered whenever en=0, from any state, on the next edge. Clears cnt, match_cnt, locked and all pulses. period holds its last value. en=1 → ARM.
  - ARM: cnt held at 0. The first rise is a reference edge only, not a measurement: cnt←1, go to MEAS.
  - MEAS / LOCK counter: each cycle without rise, cnt←cnt+1, saturating at all-ones.
  - MEAS / LOCK on rise, at the next edge:
    - period←cnt; period_vld←1; cnt←1.
    - match = |cnt−exp_n| ≤ TOL, evaluated with CNT_W+1-bit signed difference.
  - MEAS:
    - match: match_cnt++ (saturating). When it reaches LOCK_CNT, go to LOCK and set locked←1 in the same edge.
    - no match: match_cnt←0; mismatch pulse.
  - LOCK:
    - match: stay in LOCK.
    - no match: mismatch pulse; locked←0; match_cnt←0; go to MEAS. The failing period does not count toward relock.
- Timeout:
  - In MEAS/LOCK, if cnt==TIMEOUT and there is no rise that cycle: timeout pulse, locked←0, match_cnt←0, go to ARM.
  - If rise and timeout coincide, the rise wins.
- Latency: period_vld asserts on the 3rd clk edge counting the first edge that samples clk_div_in high.
- Measured period:
  - A steady divide-by-N input yields period=N. Synchronizer delay cancels.
  - Minimum resolvable period is 2. exp_n<2 never matches.
- exp_n changes take effect at the next comparison. No resynchronisation of exp_n is required.
- Asynchronous reset at any point returns to the reset values above. No partial measurement survives.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- Defined:
  - On fall in MEAS/LOCK, high_time←cnt.
  - On each rise, duty_err pulses alongside period_vld when |high_time − (cnt>>1)| > TOL. This tolerates the divide-by-N high phase of floor(N/2).
  - duty_err does not affect lock.
- Undefined: no fall logic or high-phase register. high_time and duty_err are tied to 0.

Test Plan:
- en=1, exp_n=4, TOL=0, steady divide-by-4 input → period_vld every 4 cycles with period=4; locked rises together with the 4th period_vld; no mismatch.
- Divide-by-5 input, exp_n=4, TOL=0 → mismatch with every period_vld and locked stays 0. Rerun with TOL=1 → locked after 4 periods.
- Locked on divide-by-4, then clk_div_in held low → timeout pulse 1024 cycles after the last rise; locked=0; restarting the input relocks after 1 reference edge plus 4 periods.
- Locked on divide-by-4, input switched to divide-by-6 → one mismatch pulse and locked drops on the first 6-cycle period. Setting exp_n=6 → relock after 4 periods.
- Locked, then rstn pulsed low mid-period → all outputs 0 immediately; after release, behaviour identical to a fresh start.
- DUTY_CHECK_EN, TOL=0:
  - Divide-by-5 with high phase 2 → high_time=2, no duty_err.
  - Period 6 with high phase 4 → duty_err pulse each period; locked unaffected.

Source files
------------

// File: rtl/clk_div_ratio_monitor.sv
// Measures the period of a divided clock in clk cycles, checks it against exp_n,
// and reports lock / mismatch / loss. Duty-cycle checking is built only with DUTY_CHECK_EN.
module clk_div_ratio_monitor #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clk_div_in,
  input  logic [CNT_W-1:0] exp_n,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam logic [1:0] LOCK = 2'd3;

  localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_V    = 4'(LOCK_CNT);

  logic             s1, s2, s_d;
  logic             rise;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       match_cnt;
  logic [3:0]       mc_inc;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_diff;
  logic             match;
  logic             measuring;

  assign rise      = s2 & ~s_d;
  assign measuring = (state == MEAS) || (state == LOCK);
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign mc_inc    = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;

  // One extra bit keeps the difference signed without overflow for any cnt/exp_n pair.
  assign diff     = {1'b0, cnt} - {1'b0, exp_n};
  assign abs_diff = diff[CNT_W] ? (~diff + 1'b1) : diff;
  assign match    = (abs_diff <= TOL_V) && (exp_n >= CNT_W'(2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s_d        <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= clk_div_in;
      s2         <= s1;
      s_d        <= s2;
      period_vld <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end
          ARM: begin
            // Reference edge only: starts the count, no measurement.
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEAS;
            end else begin
              cnt <= '0;
            end
          end
          MEAS, LOCK: begin
            if (rise) begin
              period     <= cnt;
              period_vld <= 1'b1;
              cnt        <= CNT_W'(1);
              if (match) begin
                if (state == MEAS) begin
                  match_cnt <= mc_inc;
                  if (mc_inc == LOCK_V) begin
                    state  <= LOCK;
                    locked <= 1'b1;
                  end
                end
              end else begin
                mismatch  <= 1'b1;
                match_cnt <= '0;
                locked    <= 1'b0;
                state     <= MEAS;
              end
            end else if (cnt == TIMEOUT_V) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              cnt       <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DUTY_CHECK_EN
  logic             fall;
  logic [CNT_W-1:0] high_q;
  logic             duty_q;
  logic [CNT_W:0]   ddiff;
  logic [CNT_W:0]   abs_ddiff;

  assign fall = ~s2 & s_d;
  // Compare against floor(period/2) so an odd divide-by-N high phase is accepted.
  assign ddiff     = {1'b0, high_q} - {2'b00, cnt[CNT_W-1:1]};
  assign abs_ddiff = ddiff[CNT_W] ? (~ddiff + 1'b1) : ddiff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      high_q <= '0;
      duty_q <= 1'b0;
    end else begin
      duty_q <= en && measuring && rise && (abs_ddiff > TOL_V);
      if (en && measuring && fall) high_q <= cnt;
    end
  end

  assign high_time = high_q;
  assign duty_err  = duty_q;
`else
  assign high_time = '0;
  assign duty_err  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ratio_monitor.sv
// Table-driven bench: two monitors (TOL=0 and TOL=1) watch the same divided clock;
// per-row pulse counts, lock position and final outputs are compared to hand-computed values.
module tb_clk_div_ratio_monitor;

`ifdef DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        clk_div_in = 1'b0;
  logic [15:0] exp_n = 16'd4;
  logic [15:0] per [2];
  logic [15:0] ht  [2];
  logic [1:0]  vld, lk, mism, to, duty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_ratio_monitor #(.CNT_W(16), .LOCK_CNT(4), .TOL(0), .TIMEOUT(1024)) u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .clk_div_in(clk_div_in), .exp_n(exp_n),
    .period(per[0]), .period_vld(vld[0]), .locked(lk[0]), .mismatch(mism[0]),
    .timeout(to[0]), .high_time(ht[0]), .duty_err(duty[0]));

  clk_div_ratio_monitor #(.CNT_W(16), .LOCK_CNT(4), .TOL(1), .TIMEOUT(1024)) u_dut1 (
    .clk(clk), .rstn(rstn), .en(en), .clk_div_in(clk_div_in), .exp_n(exp_n),
    .period(per[1]), .period_vld(vld[1]), .locked(lk[1]), .mismatch(mism[1]),
    .timeout(to[1]), .high_time(ht[1]), .duty_err(duty[1]));

  // Running event counters sampled on the falling edge
  int cyc = 0;
  int vcnt[2] = '{0, 0};
  int mcnt[2] = '{0, 0};
  int tcnt[2] = '{0, 0};
  int dcnt[2] = '{0, 0};
  int lrise[2] = '{0, 0};
  int lidx[2] = '{0, 0};
  int last_vld[2] = '{0, 0};
  logic [1:0] plock = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld[d]) begin
        vcnt[d]     <= vcnt[d] + 1;
        last_vld[d] <= cyc;
      end
      if (mism[d]) mcnt[d] <= mcnt[d] + 1;
      if (to[d])   tcnt[d] <= tcnt[d] + 1;
      if (duty[d]) dcnt[d] <= dcnt[d] + 1;
      if (lk[d] && !plock[d]) begin
        lrise[d] <= lrise[d] + 1;
        lidx[d]  <= vcnt[d] + (vld[d] ? 1 : 0);
      end
      plock[d] <= lk[d];
    end
  end

  typedef struct {
    int n, h, k, exp_p;   // divide ratio, high phase, periods driven, exp_n
    int vld;              // period_vld pulses in the row
    int m0, m1;           // mismatch pulses per DUT
    int li0, li1;         // period_vld index at which locked rises (0 = no rise)
    int lk0, lk1;         // locked at end of row
    int d0;               // duty_err pulses on TOL=0 DUT when duty checking is built
  } row_t;

  row_t rows[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic gen_period(input int n, input int h);
    for (int c = 0; c < n; c++) begin
      clk_div_in = (c < h);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_period%0d", tag, d), int'(per[d]), 0);
      chk($sformatf("%s_locked%0d", tag, d), int'(lk[d]), 0);
      chk($sformatf("%s_pulses%0d", tag, d),
          int'(vld[d] | mism[d] | to[d] | duty[d] | (ht[d] != 16'd0)), 0);
    end
  endtask

  task automatic run_row(input int r);
    row_t x;
    int bv[2], bm[2], bt[2], bd[2], bl[2];
    int e_m, e_li, e_lk, e_d;
    x = rows[r];
    for (int d = 0; d < 2; d++) begin
      bv[d] = vcnt[d]; bm[d] = mcnt[d]; bt[d] = tcnt[d];
      bd[d] = dcnt[d]; bl[d] = lrise[d];
    end
    exp_n = 16'(x.exp_p);
    for (int p = 0; p < x.k; p++) gen_period(x.n, x.h);
    for (int d = 0; d < 2; d++) begin
      e_m  = (d == 0) ? x.m0  : x.m1;
      e_li = (d == 0) ? x.li0 : x.li1;
      e_lk = (d == 0) ? x.lk0 : x.lk1;
      e_d  = (d == 0 && DUTY_ON) ? x.d0 : 0;
      chk($sformatf("row%0d_vld%0d", r, d), vcnt[d] - bv[d], x.vld);
      chk($sformatf("row%0d_mismatch%0d", r, d), mcnt[d] - bm[d], e_m);
      chk($sformatf("row%0d_timeout%0d", r, d), tcnt[d] - bt[d], 0);
      chk($sformatf("row%0d_duty%0d", r, d), dcnt[d] - bd[d], e_d);
      chk($sformatf("row%0d_locked%0d", r, d), int'(lk[d]), e_lk);
      chk($sformatf("row%0d_period%0d", r, d), int'(per[d]), x.n);
      chk($sformatf("row%0d_high%0d", r, d), int'(ht[d]), DUTY_ON ? x.h : 0);
      if (e_li > 0) begin
        chk($sformatf("row%0d_lockrise%0d", r, d), lrise[d] - bl[d], 1);
        chk($sformatf("row%0d_lockidx%0d", r, d), lidx[d] - bv[d], e_li);
      end else begin
        chk($sformatf("row%0d_lockrise%0d", r, d), lrise[d] - bl[d], 0);
      end
    end
  endtask

  task automatic timeout_seq();
    int t0[2];
    int bt[2];
    t0 = '{-1, -1};
    for (int d = 0; d < 2; d++) bt[d] = tcnt[d];
    clk_div_in = 1'b0;
    for (int i = 0; i < 1200 && (t0[0] < 0 || t0[1] < 0); i++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (to[d] && t0[d] < 0) t0[d] = cyc;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("timeout_delay%0d", d), (t0[d] < 0) ? -1 : t0[d] - last_vld[d], 1024);
      chk($sformatf("timeout_count%0d", d), tcnt[d] - bt[d], 1);
      chk($sformatf("timeout_locked%0d", d), int'(lk[d]), 0);
    end
  endtask

  task automatic reset_seq();
    clk_div_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    clk_div_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic en_latency_seq();
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle_locked%0d", d), int'(lk[d]), 0);
      chk($sformatf("idle_period_hold%0d", d), int'(per[d]), 6);
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    gen_period(6, 3);
    clk_div_in = 1'b1;
    @(posedge clk); #1;
    chk("lat_edge1_vld", int'(vld[0]), 0);
    @(posedge clk); #1;
    chk("lat_edge2_vld", int'(vld[0]), 0);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat_edge3_vld%0d", d), int'(vld[d]), 1);
      chk($sformatf("lat_period%0d", d), int'(per[d]), 6);
    end
    clk_div_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rows[0] = '{4, 2, 6, 4, 5, 0, 0, 4, 4, 1, 1, 0};
    rows[1] = '{5, 2, 4, 4, 4, 3, 0, 0, 0, 0, 1, 0};
    rows[2] = '{5, 2, 6, 4, 6, 6, 0, 0, 0, 0, 1, 0};
    rows[3] = '{4, 2, 6, 4, 6, 1, 0, 5, 0, 1, 1, 0};
    rows[4] = '{6, 3, 3, 4, 3, 2, 2, 0, 0, 0, 0, 0};
    rows[5] = '{6, 3, 6, 6, 6, 0, 0, 4, 4, 1, 1, 0};
    rows[6] = '{6, 4, 4, 6, 4, 0, 0, 0, 0, 1, 1, 3};
    rows[7] = '{6, 3, 6, 6, 5, 0, 0, 4, 4, 1, 1, 0};
    rows[8] = '{6, 3, 6, 6, 5, 0, 0, 4, 4, 1, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int r = 0; r < 9; r++) begin
      if (r == 7) timeout_seq();
      if (r == 8) reset_seq();
      run_row(r);
    end
    en_latency_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, want end before 1000000 ns");
    $fatal(1);
  end

endmodule
